slice_cmp_cascade: RTL and testbench
====================================

Name: slice_cmp_cascade

Overview:
- Downstream consumer of the 2-bit slice comparator.
- Receives one slice result per handshake: f1 (a>b), f2 (a==b), f3 (a<b).
- Slices arrive MSB slice first and together form one wide operand pair (2*SLICES bits).
- Resolves the overall magnitude relation sequentially and presents it through a valid/ready result port.

Parameters:
SLICES, 4, number of 2-bit slices per word (wide operand = 2*SLICES bits); legal range >= 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  begin new word comparison; sampled only in IDLE, or in DONE when the result is consumed
in_valid  input  1  slice result f1/f2/f3 valid this cycle
in_ready  output  1  block accepts slice this cycle
f1  input  1  slice a>b
f2  input  1  slice a==b
f3  input  1  slice a<b
out_valid  output  1  word result valid
out_ready  input  1  consumer accepts word result
gt  output  1  word a>b
eq  output  1  word a==b
lt  output  1  word a<b
err  output  1  at least one slice carried an illegal code
busy  output  1  state is SCAN

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - State goes to IDLE immediately on rst_n low.
  - in_ready=0, out_valid=0, busy=0, gt=eq=lt=0, err=0.
  - Slice counter = 0; accumulator = EQ.
- All outputs are registered, except in_ready, which is decoded from state only and never depends on in_valid.
- Slice acceptance: a slice is accepted on a rising edge where in_valid & in_ready.
- Slice code legality: the code {f1,f2,f3} is legal only if exactly one bit is set. Any other code (000, 011, 101, 110, 111) is illegal.
- States:
  - IDLE:
    - in_ready=0, out_valid=0.
    - start=1 -> SCAN; counter cleared to 0; accumulator set to EQ; error flag cleared.
  - SCAN:
    - in_ready=1, busy=1.
    - On each accepted slice:
      - Illegal code: set the error flag.
      - Legal code and accumulator == EQ: accumulator takes the slice code.
      - Legal code and accumulator already GT or LT: accumulator holds, because the first non-equal MSB slice decides.
      - Counter increments on every accepted slice.
    - Accepting slice number SLICES-1 -> DONE on the same edge. Result registers are loaded from the final accumulator (including that slice) and out_valid is asserted from the next cycle.
    - All SLICES slices are always consumed, even after early resolution, to keep the stream aligned.
    - in_valid=0 cycles: no state change; there is no timeout.
    - start while in SCAN is ignored.
  - DONE:
    - out_valid=1; in_ready=0.
    - gt/eq/lt/err are held stable until out_ready=1.
    - If err=1: gt=eq=lt=0 regardless of the accumulator.
    - Otherwise exactly one of gt/eq/lt is set.
    - On out_valid & out_ready:
      - start=1 on the same cycle -> SCAN directly (counter cleared, accumulator EQ, error cleared).
      - Otherwise -> IDLE.
    - out_valid drops the cycle after acceptance. gt/eq/lt/err hold their last values until the next load.
- Latency: out_valid rises 1 cycle after the last slice is accepted. Minimum word period is SLICES+1 cycles, or SLICES+2 cycles via IDLE.
- Counter width: max(1, $clog2(SLICES)).
- SLICES=1: a single accepted slice goes SCAN -> DONE.
- Reset mid-operation: abandons the word, forces the reset values, and returns to IDLE; no partial result is emitted.

Test Plan:
1. Word compare, a>b: start; SLICES=4; a=0xA5, b=0xA3 fed as slices EQ, EQ, GT, LT, in_valid continuous -> out_valid 1 cycle after the 4th slice with gt=1, eq=0, lt=0, err=0.
2. Equal words and early LT:
   - a=b=0x3C (4x EQ) -> eq=1.
   - Next word, slices LT, GT, GT, GT -> lt=1; all 4 slices consumed (in_ready high for 4 accepts).
3. Illegal code: slice 2 code {f1,f2,f3}=110, remaining slices legal GT -> err=1, gt=eq=lt=0.
4. Handshake stress:
   - in_valid toggled 1,0,0,1,... -> only handshake cycles count; result identical to scenario 1.
   - out_ready held 0 for 5 cycles -> out_valid and result stable throughout; drops the cycle after out_ready=1.
   - start pulsed during SCAN -> ignored.
5. Back-to-back: out_ready=1 and start=1 together in DONE -> next cycle busy=1, in_ready=1; second word 0x00 vs 0xFF -> lt=1.
6. Reset mid-scan: rst_n low asynchronously after 2 accepted slices -> outputs 0 immediately, IDLE; after release, a fresh 4-slice word 0xFF vs 0x00 -> gt=1.

Source files
------------

// File: rtl/slice_cmp_cascade.sv
// slice_cmp_cascade
// Resolves the magnitude relation of a wide operand pair from a stream of
// 2-bit slice comparator results, which arrive MSB slice first. One word is
// SLICES slices (2*SLICES bits). The word result is offered on a valid/ready port.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start                begin a new word (sampled in IDLE, or in DONE on result accept)
//   in_valid/in_ready    slice handshake; in_ready is decoded from state only
//   f1/f2/f3             slice code: a>b / a==b / a<b (exactly one bit must be set)
//   out_valid/out_ready  word result handshake
//   gt/eq/lt/err         word result; err forces gt=eq=lt=0
//   busy                 high while scanning slices
module slice_cmp_cascade #(
  parameter int unsigned SLICES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  input  logic f1,
  input  logic f2,
  input  logic f3,
  output logic out_valid,
  input  logic out_ready,
  output logic gt,
  output logic eq,
  output logic lt,
  output logic err,
  output logic busy
);

  localparam int unsigned CntW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(SLICES - 1);
  // Accumulator uses the slice code layout {gt,eq,lt}
  localparam logic [2:0] AccEq = 3'b010;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_acc;
  logic            r_err_flag;
  logic            r_out_valid;
  logic            r_gt;
  logic            r_eq;
  logic            r_lt;
  logic            r_err;
  logic            r_busy;

  logic [2:0] w_code;
  logic       w_legal;
  logic       w_accept;
  logic [2:0] w_acc_next;
  logic       w_err_next;

  assign w_code   = {f1, f2, f3};
  assign w_legal  = (w_code == 3'b100) || (w_code == 3'b010) || (w_code == 3'b001);
  assign in_ready = (r_state == StScan);
  assign w_accept = in_valid & in_ready;

  // First non-equal slice (MSB first) decides; later slices cannot override it
  assign w_acc_next = (w_legal && (r_acc == AccEq)) ? w_code : r_acc;
  assign w_err_next = r_err_flag | ~w_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_acc       <= AccEq;
      r_err_flag  <= 1'b0;
      r_out_valid <= 1'b0;
      r_gt        <= 1'b0;
      r_eq        <= 1'b0;
      r_lt        <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_state    <= StScan;
            r_cnt      <= '0;
            r_acc      <= AccEq;
            r_err_flag <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        StScan: begin
          // start is ignored here; every slice is consumed to keep the stream aligned
          if (w_accept) begin
            r_acc      <= w_acc_next;
            r_err_flag <= w_err_next;
            r_cnt      <= r_cnt + CntW'(1);
            if (r_cnt == LastIdx) begin
              r_state             <= StDone;
              r_busy              <= 1'b0;
              r_out_valid         <= 1'b1;
              {r_gt, r_eq, r_lt}  <= w_err_next ? 3'b000 : w_acc_next;
              r_err               <= w_err_next;
            end
          end
        end
        StDone: begin
          // Result registers hold until the next load, even after acceptance
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (start) begin
              r_state    <= StScan;
              r_cnt      <= '0;
              r_acc      <= AccEq;
              r_err_flag <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign gt        = r_gt;
  assign eq        = r_eq;
  assign lt        = r_lt;
  assign err       = r_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_slice_cmp_cascade.sv
// Self-checking bench for slice_cmp_cascade (SLICES=4): table-driven vectors,
// hand-written corner sequences, and random words checked against a model
// that compares whole operands numerically.
module tb_slice_cmp_cascade;

  localparam int unsigned NSl = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic f1 = 1'b0;
  logic f2 = 1'b0;
  logic f3 = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic gt, eq, lt, err, busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  slice_cmp_cascade #(.SLICES(NSl)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .f1       (f1),
    .f2       (f2),
    .f3       (f3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .gt       (gt),
    .eq       (eq),
    .lt       (lt),
    .err      (err),
    .busy     (busy)
  );

  localparam logic [2:0] CGt = 3'b100;
  localparam logic [2:0] CEq = 3'b010;
  localparam logic [2:0] CLt = 3'b001;

  // Expected results as {gt,eq,lt,err}
  localparam logic [3:0] RGt  = 4'b1000;
  localparam logic [3:0] REq  = 4'b0100;
  localparam logic [3:0] RLt  = 4'b0010;
  localparam logic [3:0] RErr = 4'b0001;

  typedef struct {
    logic [11:0] codes;  // slice 0 (MSB) in [11:9]
    logic [3:0]  exp;
    int          gap;
    bit          poke;
    int          hold;
  } vec_t;

  vec_t tbl[8];

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  function automatic logic [3:0] res();
    return {gt, eq, lt, err};
  endfunction

  task automatic start_word(input string name);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk1({name, "_busy"}, busy, 1'b1);
    chk1({name, "_in_ready"}, in_ready, 1'b1);
  endtask

  // Feeds the first n slices of codes; gap idle cycles before each slice,
  // optionally pulsing start during those idle cycles.
  task automatic feed(input string name, input logic [11:0] codes, input int gap,
                      input bit poke, input int n);
    int w;
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        start = poke;
        @(posedge clk); #1;
        start = 1'b0;
      end
      in_valid = 1'b1;
      {f1, f2, f3} = codes[11-3*k -: 3];
      w = 0;
      while (!in_ready && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      chk1({name, "_slice_ready"}, in_ready, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    {f1, f2, f3} = 3'b000;
  endtask

  // Called #1 after the edge that accepted the last slice
  task automatic finish_word(input string name, input logic [3:0] exp, input int hold);
    chk1({name, "_out_valid"}, out_valid, 1'b1);
    chk4({name, "_result"}, res(), exp);
    chk1({name, "_in_ready_done"}, in_ready, 1'b0);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk1({name, "_hold_valid"}, out_valid, 1'b1);
      chk4({name, "_hold_result"}, res(), exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk1({name, "_valid_drop"}, out_valid, 1'b0);
    chk1({name, "_idle_busy"}, busy, 1'b0);
    chk4({name, "_result_kept"}, res(), exp);
  endtask

  initial begin
    logic [7:0]  a, b;
    logic [11:0] codes;
    logic [3:0]  exp;
    logic [2:0]  ill[5];
    int          idx;

    ill[0] = 3'b000; ill[1] = 3'b011; ill[2] = 3'b101; ill[3] = 3'b110; ill[4] = 3'b111;

    tbl[0] = '{{CEq, CEq, CGt, CLt}, RGt, 0, 1'b0, 0};     // 0xA5 vs 0xA3
    tbl[1] = '{{CEq, CEq, CEq, CEq}, REq, 0, 1'b0, 0};     // 0x3C vs 0x3C
    tbl[2] = '{{CLt, CGt, CGt, CGt}, RLt, 0, 1'b0, 1};     // early LT
    tbl[3] = '{{CGt, CGt, 3'b110, CGt}, RErr, 0, 1'b0, 0}; // illegal 110
    tbl[4] = '{{CEq, CEq, CGt, CLt}, RGt, 2, 1'b1, 5};     // gaps, start poke, stall
    tbl[5] = '{{3'b000, CEq, CEq, CEq}, RErr, 1, 1'b0, 0}; // illegal 000
    tbl[6] = '{{CEq, CEq, CEq, CGt}, RGt, 0, 1'b0, 2};     // decided by LSB slice
    tbl[7] = '{{CGt, CEq, CEq, 3'b111}, RErr, 0, 1'b0, 0}; // illegal after resolve

    // Reset state
    #12;
    chk4("reset_result", res(), 4'b0000);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_in_ready", in_ready, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("idle_in_ready", in_ready, 1'b0);
    chk1("idle_busy", busy, 1'b0);

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      start_word($sformatf("tbl%0d", i));
      feed($sformatf("tbl%0d", i), tbl[i].codes, tbl[i].gap, tbl[i].poke, NSl);
      finish_word($sformatf("tbl%0d", i), tbl[i].exp, tbl[i].hold);
    end

    // Back-to-back: accept result and start in the same DONE cycle
    start_word("b2b_a");
    feed("b2b_a", tbl[0].codes, 0, 1'b0, NSl);
    chk4("b2b_a_result", res(), RGt);
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    chk1("b2b_busy", busy, 1'b1);
    chk1("b2b_in_ready", in_ready, 1'b1);
    chk1("b2b_valid_drop", out_valid, 1'b0);
    feed("b2b_b", {CLt, CLt, CLt, CLt}, 0, 1'b0, NSl);  // 0x00 vs 0xFF
    finish_word("b2b_b", RLt, 0);

    // Reset mid-scan after 2 accepted slices
    start_word("rst");
    feed("rst", {CGt, CGt, CGt, CGt}, 0, 1'b0, 2);
    #2 rst_n = 1'b0;
    #1;
    chk4("rst_async_result", res(), 4'b0000);
    chk1("rst_async_busy", busy, 1'b0);
    chk1("rst_async_in_ready", in_ready, 1'b0);
    chk1("rst_async_valid", out_valid, 1'b0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("rst_idle_busy", busy, 1'b0);
    chk1("rst_idle_valid", out_valid, 1'b0);
    start_word("rst_fresh");
    feed("rst_fresh", {CGt, CGt, CGt, CGt}, 0, 1'b0, NSl);  // 0xFF vs 0x00
    finish_word("rst_fresh", RGt, 0);

    // Random words against a whole-operand numeric model
    for (int r = 0; r < 40; r++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) b = a;
      else if ($urandom_range(0, 2) == 0) b = {a[7:4], b[3:0]};
      for (int k = 0; k < 4; k++) begin
        logic [1:0] sa, sb;
        sa = a[7-2*k -: 2];
        sb = b[7-2*k -: 2];
        codes[11-3*k -: 3] = (sa > sb) ? CGt : (sa == sb) ? CEq : CLt;
      end
      if (a > b) exp = RGt;
      else if (a == b) exp = REq;
      else exp = RLt;
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, 3);
        codes[11-3*idx -: 3] = ill[$urandom_range(0, 4)];
        exp = RErr;
      end
      start_word($sformatf("rnd%0d", r));
      feed($sformatf("rnd%0d", r), codes, $urandom_range(0, 2), 1'($urandom_range(0, 1)), NSl);
      finish_word($sformatf("rnd%0d", r), exp, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
